// File: rtl/dequeue_rr_arbiter.sv
// Round-robin arbiter feeding one dequeue shift register from NumChan word sources, tagging each loaded word with its channel.
// Optional per-channel saturating grant counters when DEQ_RR_ARB_STATS_EN is defined.
module dequeue_rr_arbiter #(
  parameter int NumChan = 4,
  parameter int DataWidth = 64,
  localparam int IdWidth = (NumChan > 1) ? $clog2(NumChan) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumChan-1:0]             req_valid_i,
  output logic [NumChan-1:0]             req_ready_o,
  input  logic [NumChan*DataWidth-1:0]   req_data_i,
  output logic                           sr_valid_o,
  input  logic                           sr_ready_i,
  output logic [DataWidth-1:0]           sr_data_o,
  input  logic                           sr_cont_data_i,
  input  logic                           sr_first_hs_i,
`ifdef DEQ_RR_ARB_STATS_EN
  input  logic                           stats_clr_i,
  output logic [NumChan*16-1:0]          grant_cnt_o,
`endif
  output logic [IdWidth-1:0]             chan_id_o,
  output logic                           chan_id_valid_o,
  output logic                           started_o
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state;
  logic [IdWidth-1:0] grant_q;
  logic [IdWidth-1:0] rr_q;
  logic [IdWidth-1:0] chan_id_q;
  logic               chan_id_valid_q;
  logic               started_q;
  logic               hs;

  // First valid channel scanning upward from the pointer with wrap-around.
  function automatic logic [IdWidth-1:0] pick(input logic [NumChan-1:0] v,
                                              input logic [IdWidth-1:0] p);
    logic [IdWidth-1:0] r;
    int idx;
    r = p;
    for (int i = NumChan - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % NumChan;
      if (v[idx]) r = IdWidth'(idx);
    end
    return r;
  endfunction

  function automatic logic [IdWidth-1:0] next_ptr(input logic [IdWidth-1:0] g);
    return (g == IdWidth'(NumChan - 1)) ? '0 : g + IdWidth'(1);
  endfunction

  assign hs = (state == OFFER) && sr_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      grant_q         <= '0;
      rr_q            <= '0;
      chan_id_q       <= '0;
      chan_id_valid_q <= 1'b0;
      started_q       <= 1'b0;
    end else begin
      // After each load the arbiter spends one cycle in IDLE, re-arbitrating
      // from the advanced pointer; this caps loads at one every two cycles.
      case (state)
        IDLE: begin
          if (|req_valid_i) begin
            grant_q <= pick(req_valid_i, rr_q);
            state   <= OFFER;
          end
        end
        OFFER: begin
          if (sr_ready_i) begin
            rr_q  <= next_ptr(grant_q);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (hs) begin
        chan_id_q       <= grant_q;
        chan_id_valid_q <= 1'b1;
        started_q       <= 1'b0;
      end else begin
        if (sr_first_hs_i) started_q <= 1'b1;
        if (!sr_cont_data_i) chan_id_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state == OFFER) req_ready_o[grant_q] = sr_ready_i;
  end

  assign sr_valid_o      = (state == OFFER);
  assign sr_data_o       = (state == OFFER) ? req_data_i[int'(grant_q)*DataWidth +: DataWidth] : '0;
  assign chan_id_o       = chan_id_q;
  assign chan_id_valid_o = chan_id_valid_q;
  assign started_o       = started_q;

`ifdef DEQ_RR_ARB_STATS_EN
  logic [NumChan-1:0][15:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (stats_clr_i) begin
      cnt_q <= '0;
    end else if (hs && (cnt_q[grant_q] != 16'hFFFF)) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 16'd1;
    end
  end

  assign grant_cnt_o = cnt_q;
`endif

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (sr_valid_o && !sr_ready_i) |=> $stable(sr_data_o));
  a_first_hs_tagged: assert property (@(posedge clk_i) disable iff (!rst_ni)
    sr_first_hs_i |-> chan_id_valid_o);
`endif

endmodule

// File: tb/tb_dequeue_rr_arbiter.sv
// Directed bench for dequeue_rr_arbiter: single load, tag lifetime, backpressure, reset mid-offer, fairness.
module tb_dequeue_rr_arbiter;
  localparam int NumChan = 4;
  localparam int DataWidth = 64;

  logic                         clk;
  logic                         rst_n;
  logic [NumChan-1:0]           req_valid;
  logic [NumChan-1:0]           req_ready;
  logic [NumChan*DataWidth-1:0] req_data;
  logic                         sr_valid;
  logic                         sr_ready;
  logic [DataWidth-1:0]         sr_data;
  logic                         sr_cont_data;
  logic                         sr_first_hs;
  logic [1:0]                   chan_id;
  logic                         chan_id_valid;
  logic                         started;
`ifdef DEQ_RR_ARB_STATS_EN
  logic                         stats_clr;
  logic [NumChan*16-1:0]        grant_cnt;
`endif

  int n_assert = 0;
  int n_fail = 0;

  dequeue_rr_arbiter #(.NumChan(NumChan), .DataWidth(DataWidth)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_data_i(req_data),
    .sr_valid_o(sr_valid),
    .sr_ready_i(sr_ready),
    .sr_data_o(sr_data),
    .sr_cont_data_i(sr_cont_data),
    .sr_first_hs_i(sr_first_hs),
`ifdef DEQ_RR_ARB_STATS_EN
    .stats_clr_i(stats_clr),
    .grant_cnt_o(grant_cnt),
`endif
    .chan_id_o(chan_id),
    .chan_id_valid_o(chan_id_valid),
    .started_o(started)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] word(input int c);
    return {16'hC0DE, 16'(c * 3 + 1), 32'hA5A5_0000 + 32'(c)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = '0;
    sr_ready     = 1'b0;
    sr_cont_data = 1'b0;
    sr_first_hs  = 1'b0;
`ifdef DEQ_RR_ARB_STATS_EN
    stats_clr    = 1'b0;
`endif
    for (int c = 0; c < NumChan; c++) req_data[c*DataWidth +: DataWidth] = word(c);

    #3;
    check("rst_sr_valid", 64'(sr_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_sr_data", sr_data, 64'd0);
    check("rst_chan_id", 64'(chan_id), 64'd0);
    check("rst_chan_id_valid", 64'(chan_id_valid), 64'd0);
    check("rst_started", 64'(started), 64'd0);

    tick();
    tick();
    rst_n = 1'b1;

    // Single request on ch2
    tick();
    req_valid = 4'b0100;
    sr_ready  = 1'b1;
    @(negedge clk);
    check("t1_idle_valid", 64'(sr_valid), 64'd0);
    tick();
    @(negedge clk);
    check("t1_sr_valid", 64'(sr_valid), 64'd1);
    check("t1_sr_data", sr_data, word(2));
    check("t1_req_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid    = '0;
    sr_cont_data = 1'b1;
    sr_first_hs  = 1'b1;
    @(negedge clk);
    check("t1_chan_id", 64'(chan_id), 64'd2);
    check("t1_chan_id_valid", 64'(chan_id_valid), 64'd1);
    check("t1_started_clr", 64'(started), 64'd0);
    check("t1_sr_valid_gap", 64'(sr_valid), 64'd0);
    check("t1_rr_ptr", 64'(dut.rr_q), 64'd3);

    // Tag lifetime
    tick();
    sr_first_hs  = 1'b0;
    sr_cont_data = 1'b0;
    @(negedge clk);
    check("tag_started", 64'(started), 64'd1);
    check("tag_valid_held", 64'(chan_id_valid), 64'd1);
    tick();
    @(negedge clk);
    check("tag_valid_drop", 64'(chan_id_valid), 64'd0);
    check("tag_id_kept", 64'(chan_id), 64'd2);

    // Backpressure: ch1 granted from pointer 3, ch0 arrives during the stall
    tick();
    req_valid = 4'b0010;
    sr_ready  = 1'b0;
    tick();
    req_valid = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_sr_data", sr_data, word(1));
      check("bp_req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    sr_ready = 1'b1;
    @(negedge clk);
    check("bp_sr_data_final", sr_data, word(1));
    check("bp_req_ready_hs", 64'(req_ready), 64'b0010);
    tick();
    req_valid = 4'b1001;
    @(negedge clk);
    check("bp_chan_id", 64'(chan_id), 64'd1);
    check("bp_gap", 64'(sr_valid), 64'd0);
    tick();
    @(negedge clk);
    check("bp_next_ch3", sr_data, word(3));
    check("bp_next_ready", 64'(req_ready), 64'b1000);
    tick();
    req_valid = 4'b0001;
    sr_ready  = 1'b0;
    @(negedge clk);
    check("bp_chan_id3", 64'(chan_id), 64'd3);
    tick();
    @(negedge clk);
    check("bp_ch0_valid", 64'(sr_valid), 64'd1);
    check("bp_ch0_data", sr_data, word(0));

    // Reset while offering
    #1;
    rst_n = 1'b0;
    #1;
    check("mr_sr_valid", 64'(sr_valid), 64'd0);
    check("mr_req_ready", 64'(req_ready), 64'd0);
    check("mr_sr_data", sr_data, 64'd0);
    check("mr_chan_id", 64'(chan_id), 64'd0);
    check("mr_chan_id_valid", 64'(chan_id_valid), 64'd0);
    check("mr_started", 64'(started), 64'd0);

    // Fairness after reset: grants 0,1,2,3,0, one every two cycles
    tick();
    rst_n        = 1'b1;
    req_valid    = 4'b1111;
    sr_ready     = 1'b1;
    sr_cont_data = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k % 2 == 1) begin
        check("fair_req_ready", 64'(req_ready), 64'(4'b0001 << (((k - 1) / 2) % 4)));
        check("fair_sr_data", sr_data, word(((k - 1) / 2) % 4));
      end else begin
        check("fair_gap", 64'(sr_valid), 64'd0);
      end
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    check("fair_last_id", 64'(chan_id), 64'd0);
    check("fair_last_valid", 64'(chan_id_valid), 64'd1);
`ifdef DEQ_RR_ARB_STATS_EN
    check("stats_ch0", 64'(grant_cnt[15:0]), 64'd2);
    check("stats_ch1", 64'(grant_cnt[31:16]), 64'd1);
    tick();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    @(negedge clk);
    check("stats_clr", 64'(grant_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
